// File: rtl/fir_coef_bank_ctrl.sv
// fir_coef_bank_ctrl: double-buffered coefficient manager for the dual-channel
// decimating FIR. The host fills the shadow bank over a valid/ready port. The
// banks swap only on a cycle without an FIR beat, or when the arm timeout expires.
// Optional feature macro: COEF_CHECKSUM_EN (checksum of the committed set).
module fir_coef_bank_ctrl #(
    parameter int TAP_COUNT    = 121,
    parameter int COEF_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 7,
    parameter int SWAP_TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         i_cfg_valid,
    output logic                         o_cfg_ready,
    input  logic [ADDR_WIDTH-1:0]        i_cfg_addr,
    input  logic signed [COEF_WIDTH-1:0] i_cfg_data,
    input  logic                         i_cfg_last,
    input  logic                         i_fir_beat,
    input  logic [ADDR_WIDTH-1:0]        i_coef_rd_addr,
    output logic signed [COEF_WIDTH-1:0] o_coef_rd_data,
    output logic                         o_active_bank,
    output logic                         o_commit_done,
    output logic                         o_busy,
    output logic                         o_err_addr,
    output logic                         o_err_count,
    output logic                         o_forced_swap,
    output logic [15:0]                  o_cfg_checksum
);

    localparam int CNT_W = ADDR_WIDTH + 2;
    localparam int TO_W  = $clog2(SWAP_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARMED,
        ST_SWAP
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_force;
    logic                    r_cfg_ready;
    logic [CNT_W-1:0]        r_wr_count;
    logic [TO_W-1:0]         r_to_count;
    logic                    r_active_bank;
    logic                    r_commit_done;
    logic                    r_err_addr;
    logic                    r_err_count;
    logic                    r_forced_swap;
    logic signed [COEF_WIDTH-1:0] r_coef_rd_data;
    logic signed [COEF_WIDTH-1:0] r_bank0 [TAP_COUNT];
    logic signed [COEF_WIDTH-1:0] r_bank1 [TAP_COUNT];

    logic w_accept;
    logic w_addr_ok;
    logic w_rd_ok;
    logic w_count_ok;
    logic w_timeout;

    // The extra top bit keeps the range compare correct even when TAP_COUNT == 2**ADDR_WIDTH.
    assign w_accept   = i_cfg_valid && r_cfg_ready;
    assign w_addr_ok  = {1'b0, i_cfg_addr} < (ADDR_WIDTH + 1)'(TAP_COUNT);
    assign w_rd_ok    = {1'b0, i_coef_rd_addr} < (ADDR_WIDTH + 1)'(TAP_COUNT);
    assign w_count_ok = (r_wr_count + CNT_W'(1)) == CNT_W'(TAP_COUNT);
    assign w_timeout  = r_to_count == TO_W'(SWAP_TIMEOUT - 1);

    // Next-state logic: load until cfg_last, then wait for a beat-free cycle or the timeout.
    always_comb begin
        w_state_next = r_state;
        w_force      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = i_cfg_last ? ST_ARMED : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept && i_cfg_last) begin
                    w_state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!i_fir_beat) begin
                    w_state_next = ST_SWAP;
                end else if (w_timeout) begin
                    w_state_next = ST_SWAP;
                    w_force      = 1'b1;
                end
            end
            ST_SWAP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register plus ready. Ready drops on the edge into ARMED and rises one cycle after entering IDLE.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state     <= ST_IDLE;
            r_cfg_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cfg_ready <= ((r_state == ST_IDLE) || (r_state == ST_LOAD)) &&
                           ((w_state_next == ST_IDLE) || (w_state_next == ST_LOAD));
        end
    end

    // Write and timeout counters, sticky error flags, and the bank swap itself.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_wr_count    <= '0;
            r_to_count    <= '0;
            r_active_bank <= 1'b0;
            r_commit_done <= 1'b0;
            r_err_addr    <= 1'b0;
            r_err_count   <= 1'b0;
            r_forced_swap <= 1'b0;
        end else begin
            r_commit_done <= (r_state == ST_SWAP);
            if (r_state == ST_SWAP) begin
                r_wr_count    <= '0;
                r_to_count    <= '0;
                r_active_bank <= ~r_active_bank;
            end else begin
                if (w_accept) begin
                    r_wr_count <= r_wr_count + CNT_W'(1);
                end
                if (r_state == ST_ARMED) begin
                    r_to_count <= r_to_count + TO_W'(1);
                end
            end
            if (w_accept && !w_addr_ok) begin
                r_err_addr <= 1'b1;
            end
            if (w_accept && i_cfg_last && !w_count_ok) begin
                r_err_count <= 1'b1;
            end
            if (w_force) begin
                r_forced_swap <= 1'b1;
            end
        end
    end

    // Shadow-bank write. Bank contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (nrst && w_accept && w_addr_ok) begin
            if (r_active_bank) begin
                r_bank0[i_cfg_addr] <= i_cfg_data;
            end else begin
                r_bank1[i_cfg_addr] <= i_cfg_data;
            end
        end
    end

    // Registered active-bank read. The bank select is taken before any toggle at the same edge.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_coef_rd_data <= '0;
        end else if (!w_rd_ok) begin
            r_coef_rd_data <= '0;
        end else if (r_active_bank) begin
            r_coef_rd_data <= r_bank1[i_coef_rd_addr];
        end else begin
            r_coef_rd_data <= r_bank0[i_coef_rd_addr];
        end
    end

`ifdef COEF_CHECKSUM_EN
    logic [15:0] r_sum;
    logic [15:0] r_cfg_checksum;

    // Running sum of accepted in-range data. It is published and cleared in the SWAP cycle.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_sum          <= '0;
            r_cfg_checksum <= '0;
        end else if (r_state == ST_SWAP) begin
            r_cfg_checksum <= r_sum;
            r_sum          <= '0;
        end else if (w_accept && w_addr_ok) begin
            r_sum <= r_sum + 16'(i_cfg_data);
        end
    end

    assign o_cfg_checksum = r_cfg_checksum;
`else
    assign o_cfg_checksum = '0;
`endif

    assign o_cfg_ready    = r_cfg_ready;
    assign o_coef_rd_data = r_coef_rd_data;
    assign o_active_bank  = r_active_bank;
    assign o_commit_done  = r_commit_done;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_err_addr     = r_err_addr;
    assign o_err_count    = r_err_count;
    assign o_forced_swap  = r_forced_swap;

endmodule

// File: tb/tb_fir_coef_bank_ctrl.sv
// Directed testbench for fir_coef_bank_ctrl. Expected values are hand-computed per scenario.
module tb_fir_coef_bank_ctrl;

    logic        clk = 1'b0;
    logic        nrst;
    logic        i_cfg_valid;
    logic        o_cfg_ready;
    logic [6:0]  i_cfg_addr;
    logic [15:0] i_cfg_data;
    logic        i_cfg_last;
    logic        i_fir_beat;
    logic [6:0]  i_coef_rd_addr;
    logic [15:0] o_coef_rd_data;
    logic        o_active_bank;
    logic        o_commit_done;
    logic        o_busy;
    logic        o_err_addr;
    logic        o_err_count;
    logic        o_forced_swap;
    logic [15:0] o_cfg_checksum;

    int checkCount   = 0;
    int errorCount   = 0;
    int commitPulses = 0;
    int cyc;

`ifdef COEF_CHECKSUM_EN
    localparam int EXP_COMMITS = 6;
`else
    localparam int EXP_COMMITS = 5;
`endif

    fir_coef_bank_ctrl dut (
        .clk            (clk),
        .nrst           (nrst),
        .i_cfg_valid    (i_cfg_valid),
        .o_cfg_ready    (o_cfg_ready),
        .i_cfg_addr     (i_cfg_addr),
        .i_cfg_data     (i_cfg_data),
        .i_cfg_last     (i_cfg_last),
        .i_fir_beat     (i_fir_beat),
        .i_coef_rd_addr (i_coef_rd_addr),
        .o_coef_rd_data (o_coef_rd_data),
        .o_active_bank  (o_active_bank),
        .o_commit_done  (o_commit_done),
        .o_busy         (o_busy),
        .o_err_addr     (o_err_addr),
        .o_err_count    (o_err_count),
        .o_forced_swap  (o_forced_swap),
        .o_cfg_checksum (o_cfg_checksum)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Count commit pulses away from the active edge.
    always @(negedge clk) begin
        if (o_commit_done === 1'b1) commitPulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // One handshake write. It waits for ready, and the write is accepted on the following edge.
    task automatic applyStimulus(input int addr, input int data, input bit last);
        int guard;
        i_cfg_valid = 1'b1;
        i_cfg_addr  = addr[6:0];
        i_cfg_data  = data[15:0];
        i_cfg_last  = last;
        guard = 0;
        while (o_cfg_ready !== 1'b1 && guard < 100) begin
            stepCycle();
            guard++;
        end
        if (guard >= 100) checkOutput("readyTimeout", 32'(o_cfg_ready), 32'd1);
        stepCycle();
        i_cfg_valid = 1'b0;
        i_cfg_last  = 1'b0;
    endtask

    task automatic loadSet(input int lo, input int hi, input int base, input int mult, input bit withLast);
        for (int a = lo; a <= hi; a++) begin
            applyStimulus(a, base + mult * a, withLast && (a == hi));
        end
    endtask

    task automatic waitCommit(output int cycles);
        cycles = 0;
        while (o_commit_done !== 1'b1 && cycles < 200) begin
            stepCycle();
            cycles++;
        end
    endtask

    task automatic readCoef(input int addr, input int expected, input string tag);
        i_coef_rd_addr = addr[6:0];
        stepCycle();
        checkOutput(tag, 32'(o_coef_rd_data), expected);
    endtask

    initial begin
        nrst           = 1'b0;
        i_cfg_valid    = 1'b0;
        i_cfg_addr     = '0;
        i_cfg_data     = '0;
        i_cfg_last     = 1'b0;
        i_fir_beat     = 1'b0;
        i_coef_rd_addr = '0;
        repeat (2) stepCycle();

        checkOutput("rstReady",    32'(o_cfg_ready),    0);
        checkOutput("rstActive",   32'(o_active_bank),  0);
        checkOutput("rstCommit",   32'(o_commit_done),  0);
        checkOutput("rstBusy",     32'(o_busy),         0);
        checkOutput("rstErrAddr",  32'(o_err_addr),     0);
        checkOutput("rstErrCount", 32'(o_err_count),    0);
        checkOutput("rstForced",   32'(o_forced_swap),  0);
        checkOutput("rstChecksum", 32'(o_cfg_checksum), 0);
        checkOutput("rstRdData",   32'(o_coef_rd_data), 0);

        nrst = 1'b1;
        stepCycle();
        checkOutput("readyAfterReset", 32'(o_cfg_ready), 1);

        // Scenario 1: a clean full load with no FIR beats swaps two cycles after the last write.
        loadSet(0, 120, 1, 1, 1);
        checkOutput("t1ArmedBusy",  32'(o_busy),        1);
        checkOutput("t1ArmedReady", 32'(o_cfg_ready),   0);
        checkOutput("t1ArmedBank",  32'(o_active_bank), 0);
        waitCommit(cyc);
        checkOutput("t1SwapLatency", cyc, 2);
        checkOutput("t1Active",      32'(o_active_bank), 1);
        stepCycle();
        checkOutput("t1PulseWidth", 32'(o_commit_done), 0);
        checkOutput("t1Idle",       32'(o_busy),        0);
        checkOutput("t1ErrAddr",    32'(o_err_addr),    0);
        checkOutput("t1ErrCount",   32'(o_err_count),   0);
        checkOutput("t1Forced",     32'(o_forced_swap), 0);
`ifndef COEF_CHECKSUM_EN
        checkOutput("t1ChecksumTied", 32'(o_cfg_checksum), 0);
`endif
        readCoef(5, 6, "t1Rd5");
        readCoef(120, 121, "t1Rd120");
        readCoef(121, 0, "t1RdOutOfRange");

        // Scenario 2: beats held for 10 ARMED cycles, then the swap follows the first beat-free cycle.
        i_fir_beat = 1'b1;
        loadSet(0, 120, 3, 2, 1);
        repeat (10) stepCycle();
        checkOutput("t2StillArmed", 32'(o_busy),        1);
        checkOutput("t2NoSwapYet",  32'(o_active_bank), 1);
        i_fir_beat = 1'b0;
        waitCommit(cyc);
        checkOutput("t2SwapLatency", cyc, 2);
        checkOutput("t2Active",      32'(o_active_bank), 0);
        checkOutput("t2Forced",      32'(o_forced_swap), 0);
        readCoef(10, 23, "t2Rd10");

        // Scenario 3: continuous beats force the swap after 64 ARMED cycles.
        i_fir_beat = 1'b1;
        loadSet(0, 120, 1000, -1, 1);
        waitCommit(cyc);
        checkOutput("t3ForcedLatency", cyc, 65);
        checkOutput("t3Forced",        32'(o_forced_swap), 1);
        checkOutput("t3Active",        32'(o_active_bank), 1);
        i_fir_beat = 1'b0;
        readCoef(7, 993, "t3Rd7");

        // Scenario 4: one out-of-range write plus 119 good writes gives 120 total, so both errors are set.
        applyStimulus(121, 16'hDEAD, 1'b0);
        loadSet(0, 118, 7, 1, 1);
        waitCommit(cyc);
        checkOutput("t4SwapLatency", cyc, 2);
        checkOutput("t4Active",      32'(o_active_bank), 0);
        checkOutput("t4ErrAddr",     32'(o_err_addr),    1);
        checkOutput("t4ErrCount",    32'(o_err_count),   1);
        checkOutput("t4ForcedStick", 32'(o_forced_swap), 1);
        readCoef(118, 125, "t4Rd118");
        readCoef(120, 243, "t4RdStaleEntry");

        // Scenario 5: reset after 50 writes discards the partial set; a full reload then swaps normally.
        loadSet(0, 49, 16'h5555, 0, 0);
        nrst = 1'b0;
        stepCycle();
        checkOutput("t5Active",   32'(o_active_bank),  0);
        checkOutput("t5Busy",     32'(o_busy),         0);
        checkOutput("t5Ready",    32'(o_cfg_ready),    0);
        checkOutput("t5ErrAddr",  32'(o_err_addr),     0);
        checkOutput("t5ErrCount", 32'(o_err_count),    0);
        checkOutput("t5Forced",   32'(o_forced_swap),  0);
        checkOutput("t5Commit",   32'(o_commit_done),  0);
        checkOutput("t5RdData",   32'(o_coef_rd_data), 0);
        nrst = 1'b1;
        loadSet(0, 120, 0, 3, 1);
        waitCommit(cyc);
        checkOutput("t5SwapLatency", cyc, 2);
        checkOutput("t5NewActive",   32'(o_active_bank), 1);
        readCoef(0, 0, "t5Rd0");
        readCoef(40, 120, "t5Rd40");
        readCoef(49, 147, "t5Rd49");

`ifdef COEF_CHECKSUM_EN
        // Scenario 6: 121 writes of 0x0100 sum to 0x7900.
        loadSet(0, 120, 16'h0100, 0, 1);
        waitCommit(cyc);
        checkOutput("t6SwapLatency", cyc, 2);
        checkOutput("t6Checksum",    32'(o_cfg_checksum), 32'h7900);
`endif

        stepCycle();
        checkOutput("commitPulseCount", commitPulses, EXP_COMMITS);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
